// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Parametrised VLIW pipeline stage register with a valid/ready handshake.
//   A 2-entry skid buffer (main + skid) keeps in_ready fully registered, so
//   it never depends combinationally on out_ready. The stage also supports
//   flush-to-bubble and a saturating stall counter.
//
// Ports
//   clk, reset      : clock and synchronous active-high reset
//   flush           : drop stage contents and any same-cycle input
//   in_valid/ready  : upstream handshake (in_ready is registered)
//   in_data/ctrl    : LANES packed payload/control slots
//   in_lane_en      : per-lane occupancy flags
//   out_valid/ready : downstream handshake
//   out_data/ctrl   : registered payload/control (main register)
//   out_lane_en     : registered per-lane occupancy
//   stall_cnt       : saturating count of cycles with out_valid & !out_ready
module pipe_stage_skid #(
    parameter int unsigned DATA_W            = 32,
    parameter int unsigned CTRL_W            = 8,
    parameter int unsigned LANES             = 2,
    parameter bit          FLUSH_CLEARS_DATA = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [LANES*CTRL_W-1:0] in_ctrl,
    input  logic [LANES-1:0]        in_lane_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [LANES*CTRL_W-1:0] out_ctrl,
    output logic [LANES-1:0]        out_lane_en,
    output logic [15:0]             stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                  state;
    logic [LANES*DATA_W-1:0] mainData, skidData;
    logic [LANES*CTRL_W-1:0] mainCtrl, skidCtrl;
    logic [LANES-1:0]        mainLaneEn, skidLaneEn;
    logic                    inReadyR, outValidR;
    logic [15:0]             stallCnt;
    logic                    accept, drain;

    assign accept = in_valid & inReadyR;
    assign drain  = outValidR & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            mainData   <= '0;
            mainCtrl   <= '0;
            mainLaneEn <= '0;
            skidData   <= '0;
            skidCtrl   <= '0;
            skidLaneEn <= '0;
            inReadyR   <= 1'b1;
            outValidR  <= 1'b0;
            stallCnt   <= '0;
        end else begin
            // Counts on current outputs, so it keeps counting in a flush cycle.
            if (outValidR && !out_ready && stallCnt != '1)
                stallCnt <= stallCnt + 16'd1;

            if (flush) begin
                state      <= EMPTY;
                inReadyR   <= 1'b1;
                outValidR  <= 1'b0;
                mainCtrl   <= '0;
                mainLaneEn <= '0;
                skidCtrl   <= '0;
                skidLaneEn <= '0;
                if (FLUSH_CLEARS_DATA) begin
                    mainData <= '0;
                    skidData <= '0;
                end
            end else begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            mainData   <= in_data;
                            mainCtrl   <= in_ctrl;
                            mainLaneEn <= in_lane_en;
                            state      <= ONE;
                            outValidR  <= 1'b1;
                        end
                    end
                    ONE: begin
                        if (accept && drain) begin
                            mainData   <= in_data;
                            mainCtrl   <= in_ctrl;
                            mainLaneEn <= in_lane_en;
                        end else if (accept) begin
                            // Main is stalled: park the new bundle in the skid.
                            skidData   <= in_data;
                            skidCtrl   <= in_ctrl;
                            skidLaneEn <= in_lane_en;
                            state      <= FULL;
                            inReadyR   <= 1'b0;
                        end else if (drain) begin
                            // Main keeps its stale contents; only valid drops.
                            state     <= EMPTY;
                            outValidR <= 1'b0;
                        end
                    end
                    FULL: begin
                        if (drain) begin
                            mainData   <= skidData;
                            mainCtrl   <= skidCtrl;
                            mainLaneEn <= skidLaneEn;
                            state      <= ONE;
                            inReadyR   <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= EMPTY;
                        inReadyR  <= 1'b1;
                        outValidR <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign in_ready    = inReadyR;
    assign out_valid   = outValidR;
    assign out_data    = mainData;
    assign out_ctrl    = mainCtrl;
    assign out_lane_en = mainLaneEn;
    assign stall_cnt   = stallCnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid
//   Drives two instances (FLUSH_CLEARS_DATA = 0 and 1) with identical
//   stimulus and compares them against a queue-based reference model.
module tb_pipe_stage_skid;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;
    localparam int unsigned LN = 2;

    typedef struct {
        logic [LN*DW-1:0] d;
        logic [LN*CW-1:0] c;
        logic [LN-1:0]    l;
    } bundle_t;

    logic             clk = 1'b0;
    logic             reset, flush, inValid, outReady;
    logic [LN*DW-1:0] inData;
    logic [LN*CW-1:0] inCtrl;
    logic [LN-1:0]    inLaneEn;

    logic             inReady0, outValid0, inReady1, outValid1;
    logic [LN*DW-1:0] outData0, outData1;
    logic [LN*CW-1:0] outCtrl0, outCtrl1;
    logic [LN-1:0]    outLaneEn0, outLaneEn1;
    logic [15:0]      stallCnt0, stallCnt1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: the stage is a FIFO of depth 2 whose head is shown
    // on the outputs; when empty the outputs show the last shown bundle.
    bundle_t     mQ[$];
    bundle_t     mDisp;
    logic [LN*DW-1:0] mData1;
    int unsigned mStall;
    bit          lastAcc;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .LANES(LN), .FLUSH_CLEARS_DATA(1'b0)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(inValid), .in_ready(inReady0),
        .in_data(inData), .in_ctrl(inCtrl), .in_lane_en(inLaneEn),
        .out_valid(outValid0), .out_ready(outReady),
        .out_data(outData0), .out_ctrl(outCtrl0), .out_lane_en(outLaneEn0),
        .stall_cnt(stallCnt0)
    );

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .LANES(LN), .FLUSH_CLEARS_DATA(1'b1)) dutClr (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(inValid), .in_ready(inReady1),
        .in_data(inData), .in_ctrl(inCtrl), .in_lane_en(inLaneEn),
        .out_valid(outValid1), .out_ready(outReady),
        .out_data(outData1), .out_ctrl(outCtrl1), .out_lane_en(outLaneEn1),
        .stall_cnt(stallCnt1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelStep();
        bundle_t b;
        bit      drn;
        lastAcc = 1'b0;
        if (reset) begin
            mQ.delete();
            mDisp  = '{d: '0, c: '0, l: '0};
            mData1 = '0;
            mStall = 0;
        end else begin
            if (mQ.size() > 0 && !outReady && mStall < 65535) mStall++;
            if (flush) begin
                mQ.delete();
                mDisp.c = '0;
                mDisp.l = '0;
                mData1  = '0;
            end else begin
                lastAcc = inValid && (mQ.size() < 2);
                drn     = (mQ.size() > 0) && outReady;
                if (drn) void'(mQ.pop_front());
                if (lastAcc) begin
                    b = '{d: inData, c: inCtrl, l: inLaneEn};
                    mQ.push_back(b);
                end
                if (mQ.size() > 0) begin
                    mDisp  = mQ[0];
                    mData1 = mQ[0].d;
                end
            end
        end
    endtask

    // One clock: update model at the edge, compare both DUTs 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        modelStep();
        #1;
        check("out_valid",    64'(outValid0),  64'(mQ.size() > 0));
        check("in_ready",     64'(inReady0),   64'(mQ.size() < 2));
        check("out_data",     64'(outData0),   64'(mDisp.d));
        check("out_ctrl",     64'(outCtrl0),   64'(mDisp.c));
        check("out_lane_en",  64'(outLaneEn0), 64'(mDisp.l));
        check("stall_cnt",    64'(stallCnt0),  64'(mStall));
        check("clr.out_valid",64'(outValid1),  64'(mQ.size() > 0));
        check("clr.in_ready", 64'(inReady1),   64'(mQ.size() < 2));
        check("clr.out_data", 64'(outData1),   64'(mData1));
        check("clr.out_ctrl", 64'(outCtrl1),   64'(mDisp.c));
        check("clr.stall_cnt",64'(stallCnt1),  64'(mStall));
    endtask

    task automatic drive(input logic v, input logic [LN*DW-1:0] d,
                         input logic [LN*CW-1:0] c, input logic [LN-1:0] l);
        inValid  = v;
        inData   = d;
        inCtrl   = c;
        inLaneEn = l;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; outReady = 1'b0;
        drive(1'b0, '0, '0, '0);
        cycle();
        check("reset.out_valid", 64'(outValid0), 64'd0);
        check("reset.in_ready",  64'(inReady0),  64'd1);
        reset = 1'b0;
        cycle();

        // Streaming at full throughput
        outReady = 1'b1;
        drive(1'b1, 64'h1, 16'h0101, 2'b11); cycle();
        check("stream.first", 64'(outData0), 64'h1);
        drive(1'b1, 64'h2, 16'h0202, 2'b01); cycle();
        drive(1'b1, 64'h3, 16'h0303, 2'b10); cycle();
        check("stream.third", 64'(outData0), 64'h3);
        drive(1'b0, '0, '0, '0); cycle();
        check("stream.stall0", 64'(stallCnt0), 64'd0);
        cycle();

        // Backpressure into skid, then drain A then B
        outReady = 1'b0;
        drive(1'b1, 64'hA, 16'h0A0A, 2'b11); cycle();
        drive(1'b1, 64'hB, 16'h0B0B, 2'b11); cycle();
        check("bp.in_ready_low", 64'(inReady0), 64'd0);
        drive(1'b1, 64'hC, 16'h0C0C, 2'b11); cycle();
        check("bp.hold_A", 64'(outData0), 64'hA);
        drive(1'b0, '0, '0, '0);
        outReady = 1'b1; cycle();
        check("bp.B_after_A", 64'(outData0), 64'hB);
        check("bp.in_ready_back", 64'(inReady0), 64'd1);
        cycle(); cycle();

        // Flush in FULL with a new bundle presented
        outReady = 1'b0;
        drive(1'b1, 64'h00000000_DEADBEEF, 16'h1111, 2'b11); cycle();
        drive(1'b1, 64'hBB, 16'h2222, 2'b11); cycle();
        flush = 1'b1;
        drive(1'b1, 64'hCC, 16'h3333, 2'b11); cycle();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        check("flush.out_valid", 64'(outValid0), 64'd0);
        check("flush.held_data", 64'(outData0), 64'h00000000_DEADBEEF);
        check("flush.clr_data",  64'(outData1), 64'd0);
        outReady = 1'b1;
        repeat (3) cycle();

        // Randomized traffic with protocol-respecting upstream
        for (int i = 0; i < 3000; i++) begin
            if (!(inValid && !lastAcc && !flush && !reset))
                drive($urandom_range(0, 3) != 0, {$urandom, $urandom},
                      16'($urandom), 2'($urandom));
            outReady = ($urandom_range(0, 9) < 6);
            flush    = ($urandom_range(0, 40) == 0);
            reset    = ($urandom_range(0, 250) == 0);
            cycle();
        end
        reset = 1'b0; flush = 1'b0;

        // Stall counter saturation
        reset = 1'b1; cycle(); reset = 1'b0;
        outReady = 1'b0;
        drive(1'b1, 64'h55, 16'h5555, 2'b01); cycle();
        drive(1'b0, '0, '0, '0);
        repeat (70000) cycle();
        check("stall.saturated", 64'(stallCnt0), 64'hFFFF);
        flush = 1'b1; cycle(); flush = 1'b0;
        check("stall.flush_keeps", 64'(stallCnt0), 64'hFFFF);
        reset = 1'b1; cycle(); reset = 1'b0;
        check("stall.reset_clears", 64'(stallCnt0), 64'd0);

        // Reset mid-FULL with a simultaneous drain
        drive(1'b1, 64'h77, 16'h7777, 2'b11); cycle();
        drive(1'b1, 64'h88, 16'h8888, 2'b11); cycle();
        drive(1'b0, '0, '0, '0);
        outReady = 1'b1; reset = 1'b1; cycle(); reset = 1'b0;
        check("rstfull.out_data", 64'(outData0), 64'd0);
        check("rstfull.in_ready", 64'(inReady0), 64'd1);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
